// File: rtl/rf_pixel_mac.sv
`default_nettype none
// ============================================================================
// rf_pixel_mac : RF-list pixel fetch and signed weighted correlation sum
// Revision     : 1.0
// ============================================================================
module rf_pixel_mac #(
    parameter int LEN   = 10,
    parameter int IMG_H = 64,
    parameter int IMG_W = 64,
    parameter int AW    = 12,
    parameter int ACC_W = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [10:0]             i_length,
    input  logic [2:0][6:0]         i_rf [0:LEN-1],
    input  logic                    i_wt_we,
    input  logic [4:0]              i_wt_addr,
    input  logic [7:0]              i_wt_data,
    output logic                    o_req,
    output logic [AW-1:0]           o_addr,
    input  logic                    i_gnt,
    input  logic                    i_rvalid,
    input  logic [7:0]              i_rdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [ACC_W-1:0] o_sum
);

    localparam int LW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q;
    logic [2:0][6:0]           rf_q  [0:LEN-1];
    logic [LW-1:0]             len_q;
    logic [LW-1:0]             idx_q;
    logic [1:0]                cnt_q;
    logic [1:0]                cnt_d;
    logic [4:0]                tag_q [0:1];
    logic                      wp_q;
    logic                      rp_q;
    logic signed [7:0]         wt_q  [0:31];
    logic signed [ACC_W-1:0]   sum_q;

    logic [6:0]                w_row;
    logic [6:0]                w_col;
    logic [4:0]                w_kidx;
    logic                      w_inb;
    logic                      w_issue;
    logic [AW-1:0]             w_addr;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_adv;
    logic                      w_last;
    logic [LW-1:0]             w_len;
    logic signed [7:0]         w_wt;
    logic signed [16:0]        w_prod;
    logic [ACC_W-1:0]          w_prod_ext;

    assign w_row   = rf_q[idx_q][0];
    assign w_col   = rf_q[idx_q][1];
    assign w_kidx  = rf_q[idx_q][2][4:0];
    // Rows/cols that wrapped upstream land above the frame and are skipped here.
    assign w_inb   = (int'(w_row) < IMG_H) && (int'(w_col) < IMG_W);
    assign w_issue = (state_q == S_ISSUE);
    assign w_addr  = AW'(w_row) * AW'(IMG_W) + AW'(w_col);

    assign o_req   = w_issue && w_inb && (cnt_q != 2'd2);
    assign o_addr  = o_req ? w_addr : '0;
    assign w_push  = o_req && i_gnt;
    assign w_pop   = i_rvalid && (cnt_q != 2'd0);
    assign w_adv   = w_issue && (!w_inb || w_push);
    assign w_last  = (idx_q == len_q - 1'b1);
    assign cnt_d   = cnt_q + {1'b0, w_push} - {1'b0, w_pop};

    assign w_len   = (i_length > 11'(LEN)) ? LW'(LEN) : LW'(i_length);

    assign w_wt       = wt_q[tag_q[rp_q]];
    assign w_prod     = 17'($signed({1'b0, i_rdata})) * 17'(w_wt);
    assign w_prod_ext = {{(ACC_W-17){w_prod[16]}}, w_prod};

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);
    assign o_sum  = sum_q;

    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_start) begin
            rf_q <= i_rf;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                wt_q[i] <= '0;
            end
        end else if (i_wt_we && state_q == S_IDLE) begin
            wt_q[i_wt_addr] <= i_wt_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            tag_q[0] <= '0;
            tag_q[1] <= '0;
            sum_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (w_push) begin
                tag_q[wp_q] <= w_kidx;
                wp_q        <= ~wp_q;
            end
            if (w_pop) begin
                rp_q  <= ~rp_q;
                sum_q <= sum_q + w_prod_ext;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        len_q   <= w_len;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        wp_q    <= 1'b0;
                        rp_q    <= 1'b0;
                        sum_q   <= '0;
                        state_q <= (w_len != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    // The index parks on the last entry so it never addresses past the list.
                    if (w_adv) begin
                        if (w_last) begin
                            state_q <= (cnt_d != 2'd0) ? S_DRAIN : S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_d == 2'd0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_pixel_mac.sv
`default_nettype none
// tb_rf_pixel_mac : scoreboard bench with an in-order SRAM responder model.
`timescale 1ns/1ps
module tb_rf_pixel_mac;

    localparam int LEN   = 10;
    localparam int IMG_H = 64;
    localparam int IMG_W = 64;
    localparam int AW    = 12;
    localparam int ACC_W = 24;

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b1;
    logic                    i_start = 1'b0;
    logic [10:0]             i_length = '0;
    logic [2:0][6:0]         i_rf [0:LEN-1];
    logic                    i_wt_we = 1'b0;
    logic [4:0]              i_wt_addr = '0;
    logic [7:0]              i_wt_data = '0;
    logic                    o_req;
    logic [AW-1:0]           o_addr;
    logic                    i_gnt = 1'b1;
    logic                    i_rvalid = 1'b0;
    logic [7:0]              i_rdata = '0;
    logic                    o_busy;
    logic                    o_done;
    logic signed [ACC_W-1:0] o_sum;

    rf_pixel_mac #(
        .LEN   (LEN),
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .AW    (AW),
        .ACC_W (ACC_W)
    ) u_dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_length  (i_length),
        .i_rf      (i_rf),
        .i_wt_we   (i_wt_we),
        .i_wt_addr (i_wt_addr),
        .i_wt_data (i_wt_data),
        .o_req     (o_req),
        .o_addr    (o_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_sum     (o_sum)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { longint sum; int dcyc; } res_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;

    logic [7:0]        pix   [0:4095];
    logic signed [7:0] wt_m  [0:31];
    logic [6:0]        ent_r [0:LEN-1];
    logic [6:0]        ent_c [0:LEN-1];
    logic [6:0]        ent_k [0:LEN-1];

    logic [AW-1:0] exp_addr_q [$];
    res_t          exp_res_q  [$];
    pend_t         pend_q     [$];

    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     start_cyc = 0;
    int     lat = 1;
    int     gnt_low = 0;
    int     out_cnt = 0;
    int     runs_done = 0;
    int     n_runs = 0;
    longint last_sum = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    res_t          r_env;

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    // SRAM responder, grant driver and output monitor.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (i_rvalid && out_cnt > 0) out_cnt--;
                if (prev_stall) begin
                    check("req_hold", o_req, 1);
                    check("addr_hold", o_addr, prev_addr);
                end
                if (o_req && i_gnt) begin
                    check("req_expected", exp_addr_q.size() > 0, 1);
                    if (exp_addr_q.size() > 0) check("addr", o_addr, exp_addr_q.pop_front());
                    pend_q.push_back('{o_addr, cyc + lat});
                    out_cnt++;
                    check("outstanding_le2", out_cnt <= 2, 1);
                end
                prev_stall = o_req && !i_gnt;
                prev_addr  = o_addr;
                if (o_done) begin
                    check("done_expected", exp_res_q.size() > 0, 1);
                    if (exp_res_q.size() > 0) begin
                        r_env = exp_res_q.pop_front();
                        check("sum", o_sum, r_env.sum);
                        if (r_env.dcyc >= 0) check("done_cycle", cyc - start_cyc + 1, r_env.dcyc);
                    end
                    runs_done++;
                end
            end
            @(posedge i_clk);
            cyc++;
            #1;
            i_gnt = !((cyc - start_cyc + 1) >= 1 && (cyc - start_cyc + 1) <= gnt_low);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                i_rvalid = 1'b1;
                i_rdata  = pix[pend_q[0].addr];
                void'(pend_q.pop_front());
            end else begin
                i_rvalid = 1'b0;
                i_rdata  = 8'($urandom);
            end
        end
    end

    task automatic wr_wt(input logic [4:0] a, input logic [7:0] d);
        @(posedge i_clk); #1;
        i_wt_we = 1'b1; i_wt_addr = a; i_wt_data = d;
        wt_m[a] = d;
        @(posedge i_clk); #1;
        i_wt_we = 1'b0;
    endtask

    task automatic set_ent(input int i, input int r, input int c, input int k);
        ent_r[i] = 7'(r); ent_c[i] = 7'(c); ent_k[i] = 7'(k);
    endtask

    task automatic set_rand_inb();
        for (int i = 0; i < LEN; i++) begin
            set_ent(i, $urandom_range(0, IMG_H-1), $urandom_range(0, IMG_W-1), $urandom_range(0, 127));
        end
    endtask

    task automatic launch(input int len, input int dcyc);
        longint                  acc = 0;
        logic signed [ACC_W-1:0] wrap;
        int                      n;
        int                      a;
        n = (len > LEN) ? LEN : len;
        for (int i = 0; i < LEN; i++) i_rf[i] = {ent_k[i], ent_c[i], ent_r[i]};
        for (int i = 0; i < n; i++) begin
            if (int'(ent_r[i]) < IMG_H && int'(ent_c[i]) < IMG_W) begin
                a = int'(ent_r[i]) * IMG_W + int'(ent_c[i]);
                exp_addr_q.push_back(AW'(a));
                acc += longint'(pix[a]) * longint'(wt_m[ent_k[i][4:0]]);
            end
        end
        wrap = acc[ACC_W-1:0];
        last_sum = longint'(wrap);
        exp_res_q.push_back('{last_sum, dcyc});
        n_runs++;
        @(posedge i_clk); #1;
        i_length  = 11'(len);
        i_start   = 1'b1;
        start_cyc = cyc + 1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        check("busy_c1", o_busy, 1);
    endtask

    task automatic finish_run();
        int k = 0;
        while (runs_done < n_runs && k < 300) begin
            @(negedge i_clk);
            k++;
        end
        check("run_done", runs_done, n_runs);
        @(negedge i_clk);
        check("idle_after", o_busy, 0);
        check("sum_hold", o_sum, last_sum);
        check("reqs_all_seen", exp_addr_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < LEN; i++) begin
            i_rf[i] = '0;
            set_ent(i, 0, 0, 0);
        end
        for (int a = 0; a < 4096; a++) pix[a] = 8'($urandom);
        for (int a = 0; a < 32; a++) wt_m[a] = '0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_req", o_req, 0);
        check("rst_addr", o_addr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sum", o_sum, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        for (int a = 0; a < 32; a++) wr_wt(5'(a), 8'($urandom));
        wr_wt(5'd3, 8'd2);
        wr_wt(5'd5, 8'hFF);
        wr_wt(5'd1, 8'd1);
        wr_wt(5'd7, 8'h80);

        // Basic two-entry sum: 10*2 + 7*(-1)
        set_ent(0, 1, 2, 3);
        set_ent(1, 4, 0, 5);
        pix[66]  = 8'd10;
        pix[256] = 8'd7;
        launch(2, 4);
        finish_run();
        check("basic_sum_13", o_sum, 13);

        launch(0, 1);
        finish_run();

        // Out-of-bounds rows are padding
        set_ent(0, 127, 0, 1);
        set_ent(1, 0, 0, 1);
        set_ent(2, 70, 0, 1);
        pix[0] = 8'd9;
        launch(3, 4);
        finish_run();

        set_ent(0, 64, 0, 3);
        set_ent(1, 0, 64, 3);
        set_ent(2, 5, 64, 5);
        set_ent(3, 127, 3, 5);
        launch(4, 5);
        finish_run();

        // Grant withheld for 5 cycles, 4-cycle read latency
        set_rand_inb();
        gnt_low = 5;
        lat     = 4;
        launch(6, -1);
        finish_run();
        gnt_low = 0;
        lat     = 1;

        // Length clamp, plus start and weight write while busy are both ignored
        set_rand_inb();
        launch(15, 12);
        @(posedge i_clk); #1;
        i_start   = 1'b1;
        i_length  = 11'd2;
        i_wt_we   = 1'b1;
        i_wt_addr = ent_k[9][4:0];
        i_wt_data = ~wt_m[ent_k[9][4:0]];
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_wt_we = 1'b0;
        finish_run();

        for (int i = 0; i < LEN; i++) begin
            set_ent(i, i, i, {i[1:0], 5'd7});
            pix[i * IMG_W + i] = 8'd255;
        end
        launch(10, 12);
        finish_run();
        check("neg_sum", o_sum, -326400);

        // Reset while draining two outstanding reads
        set_ent(0, 2, 3, 3);
        set_ent(1, 9, 9, 5);
        lat = 6;
        launch(2, -1);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        check("pre_rst_busy", o_busy, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_req", o_req, 0);
        check("mid_rst_addr", o_addr, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_sum", o_sum, 0);
        exp_res_q.delete();
        exp_addr_q.delete();
        n_runs--;
        for (int a = 0; a < 32; a++) wt_m[a] = '0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        lat   = 1;
        repeat (12) @(negedge i_clk);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_sum", o_sum, 0);
        check("post_rst_runs", runs_done, n_runs);

        // Weight table was cleared by reset, then reload and rerun
        set_rand_inb();
        for (int i = 0; i < 3; i++) pix[int'(ent_r[i]) * IMG_W + int'(ent_c[i])] = 8'(100 + i);
        launch(3, 5);
        finish_run();
        for (int i = 0; i < 3; i++) wr_wt(ent_k[i][4:0], 8'($urandom_range(1, 127)));
        launch(3, 5);
        finish_run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
